// File: rtl/tff_counter_updown.sv
// ---------------------------------------------------------------------------
// tff_counter_updown
//
// WIDTH-bit synchronous up/down counter with a programmable terminal value
// (MAX_VAL), synchronous clear, parallel load with clamping, and a choice of
// wrap-around or saturating behaviour at the count boundaries. A registered
// terminal-count pulse (tc) marks every edge on which a boundary step was
// taken, whether it wrapped or was blocked. With the default parameters and
// en=up=1 it walks 0..15..0, like the fixed 4-bit ripple-toggle counter it
// replaces.
//
// Parameters:
//   WIDTH    counter width in bits (2..32)
//   MAX_VAL  terminal count, 1 .. 2**WIDTH-1
//   SATURATE 0 = wrap at the boundaries, 1 = hold at the boundaries
//
// Ports:
//   clk       in   system clock, rising edge
//   reset     in   asynchronous reset, active low
//   en        in   count enable (one step per enabled edge)
//   up        in   direction, 1 = increment, 0 = decrement
//   clear     in   synchronous clear to zero (highest priority)
//   load      in   synchronous parallel load (below clear)
//   load_val  in   value to load, clamped to MAX_VAL
//   count     out  registered count
//   tc        out  registered terminal-count pulse
//   at_max    out  count == MAX_VAL (combinational)
//   at_min    out  count == 0 (combinational)
// ---------------------------------------------------------------------------
module tff_counter_updown #(
    parameter int unsigned      WIDTH    = 4,
    parameter logic [WIDTH-1:0] MAX_VAL  = {WIDTH{1'b1}},
    parameter bit               SATURATE = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             up,
    input  logic             clear,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             at_max,
    output logic             at_min
);

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] count_q, count_d;
    logic             tc_q, tc_d;
    logic             max_hit, min_hit;

    // Boundary decode is against MAX_VAL, not the natural roll-over of the
    // register, so a modulus below 2**WIDTH behaves correctly.
    assign max_hit = (count_q == MAX_VAL);
    assign min_hit = (count_q == '0);

    always_comb begin
        count_d = count_q;
        tc_d    = 1'b0;
        if (clear) begin
            count_d = '0;
        end else if (load) begin
            count_d = (load_val > MAX_VAL) ? MAX_VAL : load_val;
        end else if (en) begin
            if (up) begin
                if (max_hit) begin
                    // Boundary step: flagged whether it wraps or is blocked.
                    tc_d    = 1'b1;
                    count_d = SATURATE ? MAX_VAL : '0;
                end else begin
                    count_d = count_q + ONE;
                end
            end else begin
                if (min_hit) begin
                    tc_d    = 1'b1;
                    count_d = SATURATE ? '0 : MAX_VAL;
                end else begin
                    count_d = count_q - ONE;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
            tc_q    <= 1'b0;
        end else begin
            count_q <= count_d;
            tc_q    <= tc_d;
        end
    end

    assign count  = count_q;
    assign tc     = tc_q;
    assign at_max = max_hit;
    assign at_min = min_hit;

endmodule

// File: tb/tb_tff_counter_updown.sv
// ---------------------------------------------------------------------------
// tb_tff_counter_updown
//
// Three counters share one stimulus stream: the default 4-bit wrap counter,
// a modulus-10 wrap counter, and an 8-bit counter saturating at 200. Each
// clock edge the stimulus side advances a modular-arithmetic reference model
// and queues the expected outputs; a monitor pops and compares them between
// edges (and right after an asynchronous reset assertion).
// ---------------------------------------------------------------------------
module tb_tff_counter_updown;

    logic       clk;
    logic       reset;
    logic       en, up, clear, load;
    logic [7:0] lv;

    logic [3:0] cnt0, cnt1;
    logic [7:0] cnt2;
    logic       tc0, tc1, tc2;
    logic       mx0, mx1, mx2;
    logic       mn0, mn1, mn2;

    tff_counter_updown #(.WIDTH(4), .MAX_VAL(4'd15), .SATURATE(1'b0)) u_dut0 (
        .clk(clk), .reset(reset), .en(en), .up(up), .clear(clear), .load(load),
        .load_val(lv[3:0]), .count(cnt0), .tc(tc0), .at_max(mx0), .at_min(mn0)
    );

    tff_counter_updown #(.WIDTH(4), .MAX_VAL(4'd9), .SATURATE(1'b0)) u_dut1 (
        .clk(clk), .reset(reset), .en(en), .up(up), .clear(clear), .load(load),
        .load_val(lv[3:0]), .count(cnt1), .tc(tc1), .at_max(mx1), .at_min(mn1)
    );

    tff_counter_updown #(.WIDTH(8), .MAX_VAL(8'd200), .SATURATE(1'b1)) u_dut2 (
        .clk(clk), .reset(reset), .en(en), .up(up), .clear(clear), .load(load),
        .load_val(lv), .count(cnt2), .tc(tc2), .at_max(mx2), .at_min(mn2)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int checks = 0;
    int errors = 0;

    int MAXV  [3] = '{15, 9, 200};
    int MASKV [3] = '{15, 15, 255};
    bit SATV  [3] = '{1'b0, 1'b0, 1'b1};

    // Reference state: current count and tc of each counter.
    int mc [3];
    bit mt [3];

    typedef struct {
        int c0, c1, c2;
        bit t0, t1, t2;
    } exp_t;

    exp_t sb [$];

    task automatic chk(input string nm, input int act, input int expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("FAIL %s got %0d expected %0d at %0t", nm, act, expv, $time);
        end
    endtask

    function automatic int act_count(input int i);
        case (i)
            0:       return int'(cnt0);
            1:       return int'(cnt1);
            default: return int'(cnt2);
        endcase
    endfunction

    function automatic int act_flag(input int i, input int which);
        logic [2:0] t, x, n;
        t = {tc2, tc1, tc0};
        x = {mx2, mx1, mx0};
        n = {mn2, mn1, mn0};
        case (which)
            0:       return int'(t[i]);
            1:       return int'(x[i]);
            default: return int'(n[i]);
        endcase
    endfunction

    // Reference model of one clock edge, written from the counting rules with
    // modular arithmetic (wrap) or min/max limiting (saturate).
    task automatic model_edge();
        for (int i = 0; i < 3; i++) begin
            int m, v, c;
            m = MAXV[i];
            v = int'(lv) & MASKV[i];
            c = mc[i];
            if (!reset) begin
                mc[i] = 0; mt[i] = 1'b0;
            end else if (clear) begin
                mc[i] = 0; mt[i] = 1'b0;
            end else if (load) begin
                mc[i] = (v > m) ? m : v; mt[i] = 1'b0;
            end else if (en && up) begin
                if (SATV[i]) begin
                    mt[i] = (c + 1 > m);
                    mc[i] = (c + 1 > m) ? m : c + 1;
                end else begin
                    mc[i] = (c + 1) % (m + 1);
                    mt[i] = (mc[i] == 0);
                end
            end else if (en) begin
                if (SATV[i]) begin
                    mt[i] = (c - 1 < 0);
                    mc[i] = (c - 1 < 0) ? 0 : c - 1;
                end else begin
                    mc[i] = (c + m) % (m + 1);
                    mt[i] = (mc[i] == m);
                end
            end else begin
                mt[i] = 1'b0;
            end
        end
    endtask

    task automatic push_expect();
        exp_t e;
        e.c0 = mc[0]; e.c1 = mc[1]; e.c2 = mc[2];
        e.t0 = mt[0]; e.t1 = mt[1]; e.t2 = mt[2];
        sb.push_back(e);
    endtask

    // Monitor: outputs are compared between clock edges, and also just after
    // reset falls so the asynchronous clear is seen before the next edge.
    initial begin
        exp_t e;
        int   ec [3];
        bit   et [3];
        forever begin
            @(negedge clk or negedge reset);
            #1;
            while (sb.size() > 0) begin
                e = sb.pop_front();
                ec = '{e.c0, e.c1, e.c2};
                et = '{e.t0, e.t1, e.t2};
                for (int i = 0; i < 3; i++) begin
                    chk($sformatf("dut%0d count", i), act_count(i), ec[i]);
                    chk($sformatf("dut%0d tc", i), act_flag(i, 0), int'(et[i]));
                    chk($sformatf("dut%0d at_max", i), act_flag(i, 1), int'(ec[i] == MAXV[i]));
                    chk($sformatf("dut%0d at_min", i), act_flag(i, 2), int'(ec[i] == 0));
                end
            end
        end
    end

    task automatic drive(input bit c, input bit l, input bit e, input bit u, input int v);
        clear = c;
        load  = l;
        en    = e;
        up    = u;
        lv    = 8'(v);
    endtask

    task automatic cycle();
        @(posedge clk);
        model_edge();
        push_expect();
        #1;
    endtask

    task automatic cycles(input int n);
        for (int k = 0; k < n; k++) cycle();
    endtask

    task automatic async_reset();
        @(negedge clk);
        #2;
        for (int i = 0; i < 3; i++) begin
            mc[i] = 0;
            mt[i] = 1'b0;
        end
        push_expect();
        reset = 1'b0;
        #1;
    endtask

    initial begin
        int bias;
        reset = 1'b0;
        drive(0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            mc[i] = 0;
            mt[i] = 1'b0;
        end

        // Reset held low: everything stays at zero.
        cycles(3);
        reset = 1'b1;

        // Free-running up count: full 0..15..0 and mod-10 wrap.
        drive(0, 0, 1, 1, 0);
        cycles(17);

        // Down through zero from 1.
        drive(0, 1, 0, 0, 1);
        cycle();
        drive(0, 0, 1, 0, 0);
        cycles(3);

        // Saturating approach to 200 from 198.
        drive(0, 1, 0, 0, 198);
        cycle();
        drive(0, 0, 1, 1, 0);
        cycles(5);

        // Decrement blocked at zero.
        drive(1, 0, 0, 0, 0);
        cycle();
        drive(0, 0, 1, 0, 0);
        cycles(2);

        // Priority: clear beats load and en; load clamps above MAX_VAL.
        drive(1, 1, 1, 1, 14);
        cycle();
        drive(0, 1, 1, 1, 14);
        cycle();
        drive(0, 1, 1, 1, 255);
        cycle();

        // Async reset right after a wrap cancels the tc pulse.
        drive(0, 1, 0, 0, 9);
        cycle();
        drive(0, 0, 1, 1, 0);
        cycle();
        async_reset();
        cycles(2);
        reset = 1'b1;
        cycle();

        // Enable gating, then direction flip every cycle.
        drive(0, 1, 0, 0, 5);
        cycle();
        drive(0, 0, 0, 1, 0);
        cycles(4);
        for (int k = 0; k < 4; k++) begin
            drive(0, 0, 1, (k % 2) == 0, 0);
            cycle();
        end

        // Randomized operation with phases biased up, down or mixed.
        bias = 0;
        for (int n = 0; n < 400; n++) begin
            int v;
            if (n % 50 == 0) bias = int'($urandom_range(0, 2));
            case ($urandom_range(0, 3))
                0:       v = int'($urandom_range(0, 255));
                1:       v = int'($urandom_range(190, 255));
                2:       v = int'($urandom_range(0, 15));
                default: v = int'($urandom_range(5, 12));
            endcase
            drive($urandom_range(0, 31) == 0,
                  $urandom_range(0, 15) == 0,
                  $urandom_range(0, 3) != 0,
                  (bias == 1) ? 1'b1 : (bias == 0) ? 1'b0 : 1'($urandom_range(0, 1)),
                  v);
            cycle();
        end

        drive(0, 0, 0, 0, 0);
        for (int k = 0; k < 10 && sb.size() > 0; k++) @(negedge clk);
        #2;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard drain got %0d pending expected 0", sb.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
